// File: rtl/reg_check_pkg.sv
// Shared definitions for the register-file self-check monitor.
package reg_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic MODE_CYCLE = 1'b0;
    localparam logic MODE_PC    = 1'b1;

endpackage

// File: rtl/reg_check_seq_gen.sv
// Walks the checked register window: read index and expected value advance together,
// the expected value by repeated addition of the step rather than a multiply.
module reg_check_seq_gen #(
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 5,
    parameter int NUM_CHECKS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [IDX_W-1:0]  base_idx,
    input  logic [DATA_W-1:0] base_val,
    input  logic [DATA_W-1:0] step_val,
    output logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] exp_data,
    output logic              last
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHECKS - 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // NOTE: every combinational output gets its hold value first, so no path can infer a latch.
    always_comb begin
        idx_d = idx_q;
        exp_d = exp_q;
        cnt_d = cnt_q;
        if (load) begin
            idx_d = base_idx;
            exp_d = base_val;
            cnt_d = '0;
        end else if (step) begin
            idx_d = idx_q + 1'b1;   // wraps modulo 2^IDX_W by width
            exp_d = exp_q + step_val;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            exp_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            exp_q <= exp_d;
            cnt_q <= cnt_d;
        end
    end

    assign rd_idx   = idx_q;
    assign exp_data = exp_q;
    assign last     = (cnt_q == LAST_CNT);

endmodule

// File: rtl/reg_check_monitor.sv
// Run/trigger/scan controller: waits for a cycle count or halt PC, then compares a
// window of register-file entries against an arithmetic sequence and reports results.
module reg_check_monitor
    import reg_check_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IDX_W      = 5,
    parameter int NUM_CHECKS = 8,
    parameter int CYC_W      = 32,
    parameter int PC_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [CYC_W-1:0]  check_cycle,
    input  logic [PC_W-1:0]   target_pc,
    input  logic [IDX_W-1:0]  base_reg,
    input  logic [DATA_W-1:0] exp_base,
    input  logic [DATA_W-1:0] exp_step,
    input  logic [PC_W-1:0]   pc,
    output logic [IDX_W-1:0]  rf_rd_idx,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W:0]    fail_count,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [PC_W-1:0]   pc_snapshot
);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [CYC_W-1:0]  check_cycle_q, check_cycle_d;
    logic [PC_W-1:0]   target_pc_q, target_pc_d;
    logic [IDX_W-1:0]  base_reg_q, base_reg_d;
    logic [DATA_W-1:0] exp_base_q, exp_base_d;
    logic [DATA_W-1:0] exp_step_q, exp_step_d;
    logic [CYC_W-1:0]  cycle_count_q, cycle_count_d;
    logic [IDX_W:0]    fail_count_q, fail_count_d;
    logic [IDX_W-1:0]  first_fail_q, first_fail_d;
    logic              timeout_q, timeout_d;
    logic [PC_W-1:0]   pc_snapshot_q, pc_snapshot_d;

    logic [CYC_W-1:0]  cycle_inc;
    logic              seq_load, seq_step, seq_last;
    logic [IDX_W-1:0]  seq_idx;
    logic [DATA_W-1:0] seq_exp;

    assign seq_load = (state_q == ST_RUN);
    assign seq_step = (state_q == ST_SCAN);

    reg_check_seq_gen #(
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W),
        .NUM_CHECKS (NUM_CHECKS)
    ) u_seq_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seq_load),
        .step     (seq_step),
        .base_idx (base_reg_q),
        .base_val (exp_base_q),
        .step_val (exp_step_q),
        .rd_idx   (seq_idx),
        .exp_data (seq_exp),
        .last     (seq_last)
    );

    // Saturating increment: a long run pins at all-ones instead of wrapping.
    assign cycle_inc = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        check_cycle_d = check_cycle_q;
        target_pc_d   = target_pc_q;
        base_reg_d    = base_reg_q;
        exp_base_d    = exp_base_q;
        exp_step_d    = exp_step_q;
        cycle_count_d = cycle_count_q;
        fail_count_d  = fail_count_q;
        first_fail_d  = first_fail_q;
        timeout_d     = timeout_q;
        pc_snapshot_d = pc_snapshot_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mode_d        = mode;
                    check_cycle_d = (check_cycle == '0) ? CYC_W'(1) : check_cycle;
                    target_pc_d   = target_pc;
                    base_reg_d    = base_reg;
                    exp_base_d    = exp_base;
                    exp_step_d    = exp_step;
                    cycle_count_d = '0;
                    fail_count_d  = '0;
                    first_fail_d  = '0;
                    timeout_d     = 1'b0;
                    pc_snapshot_d = '0;
                    state_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                cycle_count_d = cycle_inc;
                // A PC match takes priority over a timeout on the same edge.
                if (mode_q == MODE_PC && pc == target_pc_q) begin
                    pc_snapshot_d = pc;
                    state_d       = ST_SCAN;
                end else if (cycle_inc == check_cycle_q) begin
                    if (mode_q == MODE_PC) begin
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        pc_snapshot_d = pc;
                        state_d       = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                cycle_count_d = cycle_inc;
                if (rf_rd_data != seq_exp) begin
                    fail_count_d = fail_count_q + 1'b1;
                    if (fail_count_q == '0) first_fail_d = seq_idx;
                end
                if (seq_last) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_CYCLE;
            check_cycle_q <= '0;
            target_pc_q   <= '0;
            base_reg_q    <= '0;
            exp_base_q    <= '0;
            exp_step_q    <= '0;
            cycle_count_q <= '0;
            fail_count_q  <= '0;
            first_fail_q  <= '0;
            timeout_q     <= 1'b0;
            pc_snapshot_q <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            check_cycle_q <= check_cycle_d;
            target_pc_q   <= target_pc_d;
            base_reg_q    <= base_reg_d;
            exp_base_q    <= exp_base_d;
            exp_step_q    <= exp_step_d;
            cycle_count_q <= cycle_count_d;
            fail_count_q  <= fail_count_d;
            first_fail_q  <= first_fail_d;
            timeout_q     <= timeout_d;
            pc_snapshot_q <= pc_snapshot_d;
        end
    end

    assign rf_rd_idx      = (state_q == ST_SCAN) ? seq_idx : base_reg_q;
    assign busy           = (state_q == ST_RUN) || (state_q == ST_SCAN);
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (fail_count_q == '0) && !timeout_q;
    assign timeout        = timeout_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_q;
    assign cycle_count    = cycle_count_q;
    assign pc_snapshot    = pc_snapshot_q;

endmodule

// File: tb/tb_reg_check_monitor.sv
// Directed bench for reg_check_monitor: expected run results are queued at start and
// compared when done rises; a second instance covers a 4-register window wrapping the file.
module tb_reg_check_monitor;

    typedef struct {
        int          edges;
        logic [5:0]  fails;
        logic [4:0]  first;
        logic        pass;
        logic        tmo;
        logic [31:0] cyc;
        logic [31:0] snap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, start4 = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] check_cycle = '0, target_pc = '0, exp_base = '0, exp_step = '0, pc = '0;
    logic [4:0]  base_reg = '0;

    logic [4:0]  rf_rd_idx, first_fail_idx, rf_rd_idx4, first_fail_idx4;
    logic [31:0] rf_rd_data, cycle_count, pc_snapshot, rf_rd_data4, cycle_count4, pc_snapshot4;
    logic        busy, done, pass, timeout, busy4, done4, pass4, timeout4;
    logic [5:0]  fail_count, fail_count4;

    logic [31:0] rf [32];
    exp_t        sb [$];
    logic [4:0]  idx_exp [$];
    int          idx_from = 0;
    bit          pc_ramp = 1'b0;
    bit          hold_idx = 1'b0;
    int          probe_edge = -1;
    int          n_tests = 0;
    int          n_fail = 0;
    int          edges;

    assign rf_rd_data  = rf[rf_rd_idx];
    assign rf_rd_data4 = rf[rf_rd_idx4];

    always #5 clk = ~clk;

    reg_check_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .check_cycle(check_cycle),
        .target_pc(target_pc), .base_reg(base_reg), .exp_base(exp_base), .exp_step(exp_step),
        .pc(pc), .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .fail_count(fail_count), .first_fail_idx(first_fail_idx),
        .cycle_count(cycle_count), .pc_snapshot(pc_snapshot)
    );

    reg_check_monitor #(.NUM_CHECKS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .check_cycle(check_cycle),
        .target_pc(target_pc), .base_reg(base_reg), .exp_base(exp_base), .exp_step(exp_step),
        .pc(pc), .rf_rd_idx(rf_rd_idx4), .rf_rd_data(rf_rd_data4), .busy(busy4), .done(done4),
        .pass(pass4), .timeout(timeout4), .fail_count(fail_count4),
        .first_fail_idx(first_fail_idx4), .cycle_count(cycle_count4), .pc_snapshot(pc_snapshot4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rf_ramp();
        for (int r = 0; r < 32; r++) rf[r] = 32'hDEAD_0000 | 32'(r);
        for (int k = 0; k < 8; k++) rf[8 + k] = 32'(4 + 4 * k);
    endtask

    task automatic set_cfg(input logic m, input logic [31:0] cc, input logic [31:0] tpc,
                           input logic [4:0] br, input logic [31:0] eb, input logic [31:0] es);
        mode = m; check_cycle = cc; target_pc = tpc; base_reg = br; exp_base = eb; exp_step = es;
    endtask

    task automatic pulse_start(input bit use4);
        if (use4) start4 = 1'b1; else start = 1'b1;
        tick();
        start = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic wait_done(input bit use4, input int budget, input int from, output int n);
        n = from;
        while (!(use4 ? done4 : done) && n < budget) begin
            if (pc_ramp) pc = 32'd96 + 32'(4 * (n + 1));
            tick();
            n++;
            if (use4 && idx_exp.size() > 0 && n >= idx_from)
                check("rd_idx_seq", 64'(rf_rd_idx4), 64'(idx_exp.pop_front()));
            if (hold_idx) check("rd_idx_hold", 64'(rf_rd_idx), 64'(base_reg));
            if (n == probe_edge) begin
                check("scan_entry_cycle", 64'(cycle_count), 64'd6);
                check("scan_entry_snap", 64'(pc_snapshot), 64'd120);
            end
        end
        if (!(use4 ? done4 : done)) check("done_within_budget", 64'd0, 64'd1);
    endtask

    task automatic check_result(input bit use4, input int n);
        exp_t e;
        e = sb.pop_front();
        check("latency", 64'(n), 64'(e.edges));
        check("fail_count", 64'(use4 ? fail_count4 : fail_count), 64'(e.fails));
        check("first_fail_idx", 64'(use4 ? first_fail_idx4 : first_fail_idx), 64'(e.first));
        check("pass", 64'(use4 ? pass4 : pass), 64'(e.pass));
        check("timeout", 64'(use4 ? timeout4 : timeout), 64'(e.tmo));
        check("cycle_count", 64'(use4 ? cycle_count4 : cycle_count), 64'(e.cyc));
        check("pc_snapshot", 64'(use4 ? pc_snapshot4 : pc_snapshot), 64'(e.snap));
        check("busy_low", 64'(use4 ? busy4 : busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        load_rf_ramp();

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_fail_count", 64'(fail_count), 64'd0);
        check("rst_first_fail", 64'(first_fail_idx), 64'd0);
        check("rst_cycle_count", 64'(cycle_count), 64'd0);
        check("rst_pc_snapshot", 64'(pc_snapshot), 64'd0);
        check("rst_rd_idx", 64'(rf_rd_idx), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Mode 0 clean run: 14 + 8 edges
        set_cfg(1'b0, 32'd14, 32'd0, 5'd8, 32'd4, 32'd4);
        pc = 32'h40;
        sb.push_back('{22, 6'd0, 5'd0, 1'b1, 1'b0, 32'd22, 32'h40});
        pulse_start(1'b0);
        wait_done(1'b0, 100, 0, edges);
        check_result(1'b0, edges);

        // Two corrupted registers
        rf[11] = 32'd15;
        rf[13] = 32'd0;
        sb.push_back('{22, 6'd2, 5'd11, 1'b0, 1'b0, 32'd22, 32'h40});
        pulse_start(1'b0);
        wait_done(1'b0, 100, 0, edges);
        check_result(1'b0, edges);
        load_rf_ramp();

        // Mode 1 PC match at edge 6, then 8 scan edges
        set_cfg(1'b1, 32'd50, 32'd120, 5'd8, 32'd4, 32'd4);
        pc_ramp = 1'b1;
        probe_edge = 6;
        pc = 32'd96;
        sb.push_back('{14, 6'd0, 5'd0, 1'b1, 1'b0, 32'd14, 32'd120});
        pulse_start(1'b0);
        wait_done(1'b0, 100, 0, edges);
        check_result(1'b0, edges);
        pc_ramp = 1'b0;
        probe_edge = -1;

        // Mode 1 timeout: pc never matches, read index stays at base
        pc = 32'd0;
        set_cfg(1'b1, 32'd10, 32'd120, 5'd8, 32'd4, 32'd4);
        hold_idx = 1'b1;
        sb.push_back('{10, 6'd0, 5'd0, 1'b0, 1'b1, 32'd10, 32'd0});
        pulse_start(1'b0);
        wait_done(1'b0, 100, 0, edges);
        check_result(1'b0, edges);
        hold_idx = 1'b0;

        // Four-register window wrapping both index and data
        rf[30] = 32'hFFFF_FFFE;
        rf[31] = 32'hFFFF_FFFF;
        rf[0]  = 32'h0000_0000;
        rf[1]  = 32'h0000_0001;
        pc = 32'h200;
        set_cfg(1'b0, 32'd3, 32'd0, 5'd30, 32'hFFFF_FFFE, 32'd1);
        idx_exp = '{5'd30, 5'd31, 5'd0, 5'd1};
        idx_from = 3;
        sb.push_back('{7, 6'd0, 5'd0, 1'b1, 1'b0, 32'd7, 32'h200});
        pulse_start(1'b1);
        wait_done(1'b1, 100, 0, edges);
        check_result(1'b1, edges);
        check("rd_idx_after_scan", 64'(rf_rd_idx4), 64'd30);
        check("idx_seq_consumed", 64'(idx_exp.size()), 64'd0);
        load_rf_ramp();

        // start during RUN with a different config must be ignored
        pc = 32'h40;
        set_cfg(1'b0, 32'd14, 32'd0, 5'd8, 32'd4, 32'd4);
        sb.push_back('{22, 6'd0, 5'd0, 1'b1, 1'b0, 32'd22, 32'h40});
        pulse_start(1'b0);
        repeat (3) tick();
        set_cfg(1'b1, 32'd5, 32'h40, 5'd0, 32'd99, 32'd7);
        pulse_start(1'b0);
        wait_done(1'b0, 100, 4, edges);
        check_result(1'b0, edges);

        // Reset mid-SCAN with one mismatch already counted
        set_cfg(1'b0, 32'd14, 32'd0, 5'd8, 32'd4, 32'd4);
        rf[8] = 32'd0;
        pulse_start(1'b0);
        repeat (16) tick();
        check("pre_reset_fail_count", 64'(fail_count), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_fail_count", 64'(fail_count), 64'd0);
        check("abort_cycle_count", 64'(cycle_count), 64'd0);
        check("abort_pc_snapshot", 64'(pc_snapshot), 64'd0);
        check("abort_rd_idx", 64'(rf_rd_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_after_abort", 64'({busy, done}), 64'd0);
        load_rf_ramp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_check_monitor.md
Name: reg_check_monitor

Overview:
- Synthesizable self-check block for the pipelined MIPS core. It watches a run, then reads a window of register-file entries and compares each against an arithmetic expected sequence.
- Generalises the fixed "check $t0..$t7 at cycle 14" bench into hardware:
  - parametrised register count and width;
  - fixed-cycle or PC-match trigger;
  - timeout, and pass/fail reporting.
- Sits beside Top and drives a spare combinational register-file read port.

Parameters:
- DATA_W, 32, register and expected-value width.
- IDX_W, 5, register index width.
- NUM_CHECKS, 8, registers compared per run (1..2^IDX_W).
- CYC_W, 32, cycle counter width.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin run; config sampled on this edge.
- mode  in  1  0 = trigger at check_cycle; 1 = trigger on pc==target_pc, with check_cycle as timeout.
- check_cycle  in  CYC_W  trigger cycle (mode 0) or timeout (mode 1); 0 treated as 1.
- target_pc  in  PC_W  halt PC for mode 1.
- base_reg  in  IDX_W  first register index checked.
- exp_base  in  DATA_W  expected value of first register.
- exp_step  in  DATA_W  expected increment per subsequent register.
- pc  in  PC_W  core program counter.
- rf_rd_idx  out  IDX_W  register-file read index.
- rf_rd_data  in  DATA_W  combinational read data for rf_rd_idx.
- busy  out  1  run in progress.
- done  out  1  results valid; held until next start.
- pass  out  1  done && fail_count==0 && !timeout.
- timeout  out  1  mode 1 only: pc never matched.
- fail_count  out  IDX_W+1  mismatching registers.
- first_fail_idx  out  IDX_W  register index of first mismatch; 0 if none.
- cycle_count  out  CYC_W  cycles elapsed since start.
- pc_snapshot  out  PC_W  pc sampled at trigger.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including rf_rd_idx; the scan index is cleared. Reset asserted mid-RUN or mid-SCAN aborts the run with no partial results.
- FSM states: IDLE, RUN, SCAN, DONE.
- IDLE/DONE + start=1:
  - latch mode, check_cycle, target_pc, base_reg, exp_base, exp_step;
  - clear cycle_count, fail_count, first_fail_idx, timeout, done, pc_snapshot;
  - go to RUN; busy=1.
- start while busy: ignored.
- RUN:
  - cycle_count increments by 1 every edge.
  - Mode 0: on the edge where the incremented value equals check_cycle, capture pc_snapshot and enter SCAN.
  - Mode 1: if sampled pc==target_pc, capture pc_snapshot and enter SCAN (PC match wins over a simultaneous timeout). Else if the incremented count equals check_cycle, set timeout=1 and go to DONE with no scan.
- SCAN:
  - Scan index i runs 0..NUM_CHECKS-1, one register per cycle.
  - rf_rd_idx = base_reg + i, mod 2^IDX_W (wraps 31 -> 0).
  - Expected value = exp_base + i*exp_step, truncated to DATA_W; compute it incrementally with an accumulator, no multiplier.
  - Each edge compares rf_rd_data with the expected value. On mismatch, fail_count++; on the first mismatch, latch first_fail_idx = rf_rd_idx.
  - cycle_count keeps incrementing during SCAN.
  - After the i=NUM_CHECKS-1 edge, go to DONE.
- DONE: busy=0, done=1; pass combinational from the latched results; all results hold until start or reset.
- Latency, mode 0: done rises check_cycle+NUM_CHECKS edges after the start edge.
- Outside SCAN, rf_rd_idx holds base_reg (latched).
- cycle_count saturates at all-ones; it never wraps.

Decomposition:
- Shared package reg_check_pkg holds:
  - FSM state encoding (IDLE=0, RUN=1, SCAN=2, DONE=3);
  - mode constants MODE_CYCLE=0, MODE_PC=1.
- One natural sub-module: reg_check_seq_gen. It is the index/expected-value accumulator (load on SCAN entry, step per cycle) and outputs rf_rd_idx and expected data.
- Top-level keeps the FSM, counters and result registers.

Test Plan:
- Mode 0, check_cycle=14, base_reg=8, exp_base=4, exp_step=4, regs 8..15 = 4,8,...,32 -> done 22 edges after start; pass=1; fail_count=0; cycle_count=22.
- Same config, reg 11 = 15 and reg 13 = 0 -> fail_count=2, first_fail_idx=11, pass=0.
- Mode 1, target_pc=120, check_cycle=50, pc reaches 120 at cycle 6 -> pc_snapshot=120, SCAN entered with cycle_count=6, timeout=0.
- Mode 1, pc never 120, check_cycle=10 -> done at cycle 10, timeout=1, pass=0, fail_count=0, no rf reads beyond base_reg.
- NUM_CHECKS=4, base_reg=30, exp_base=0xFFFFFFFE, exp_step=1 -> rf_rd_idx 30,31,0,1; expected 0xFFFFFFFE, 0xFFFFFFFF, 0, 1 (wrap in both).
- rst_n pulsed low mid-SCAN, plus start asserted during RUN -> outputs immediately 0, FSM IDLE; mid-RUN start has no effect on the latched config.
